// File: rtl/mss_ccc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mss_ccc_ctrl_pkg
//  Description : Shared types and constants for the MSS CCC reconfiguration
//                sequencer: FSM state encoding, default parameter values and
//                bit offsets of the fields inside the packed config word.
//  Revision    : 1.0 - initial release
// ============================================================================
package mss_ccc_ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT     = 3'd1,
        ST_UPDATE    = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    // Default parameter values for the full-size CCC
    localparam int DEF_CFG_W        = 81;
    localparam int DEF_SCLK_DIV     = 4;
    localparam int DEF_LOCK_STABLE  = 256;
    localparam int DEF_LOCK_TIMEOUT = 65535;

    // Field layout of the 81-bit configuration word (LSB offsets and widths),
    // used by the register block that assembles CFG_DATA.
    localparam int FINDIV_OFS  = 0;   localparam int FINDIV_W  = 7;
    localparam int FBDIV_OFS   = 7;   localparam int FBDIV_W   = 7;
    localparam int OADIV_OFS   = 14;  localparam int OADIV_W   = 5;
    localparam int OBDIV_OFS   = 19;  localparam int OBDIV_W   = 5;
    localparam int OCDIV_OFS   = 24;  localparam int OCDIV_W   = 5;
    localparam int OAMUX_OFS   = 29;  localparam int OAMUX_W   = 3;
    localparam int OBMUX_OFS   = 32;  localparam int OBMUX_W   = 3;
    localparam int OCMUX_OFS   = 35;  localparam int OCMUX_W   = 3;
    localparam int BYPASS_OFS  = 38;  localparam int BYPASS_W  = 3;
    localparam int DLYA_OFS    = 41;  localparam int DLYA_W    = 5;
    localparam int DLYB_OFS    = 46;  localparam int DLYB_W    = 5;
    localparam int DLYC_OFS    = 51;  localparam int DLYC_W    = 5;
    localparam int FBDLY_OFS   = 56;  localparam int FBDLY_W   = 5;
    localparam int FBSEL_OFS   = 61;  localparam int FBSEL_W   = 2;
    localparam int XDLYSEL_OFS = 63;  localparam int XDLYSEL_W = 1;
    // Bits 64..80 are vendor-reserved and must be written as zero.
    localparam int RSVD_OFS    = 64;  localparam int RSVD_W    = 17;

endpackage : mss_ccc_ctrl_pkg
`default_nettype wire

// File: rtl/mss_ccc_lock_sync.sv
`default_nettype none
// ============================================================================
//  Module      : mss_ccc_lock_sync
//  Description : Two-flop synchronizer bringing the asynchronous PLL lock
//                indication into the FAB_CLK domain. Resets to "not locked".
//  Revision    : 1.0 - initial release
// ============================================================================
module mss_ccc_lock_sync
    import mss_ccc_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two-stage synchronizer; first stage may go metastable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule : mss_ccc_lock_sync
`default_nettype wire

// File: rtl/mss_ccc_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mss_ccc_reconfig_ctrl
//  Description : Serially loads a new configuration word into the CCC dynamic
//                configuration chain, holds the fabric in reset while the PLL
//                relocks, qualifies lock with a stability window and timeout,
//                and re-enters the lock wait on run-time loss of lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module mss_ccc_reconfig_ctrl
    import mss_ccc_ctrl_pkg::*;
#(
    parameter int CFG_W        = DEF_CFG_W,
    parameter int SCLK_DIV     = DEF_SCLK_DIV,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             CFG_REQ,
    input  logic [CFG_W-1:0] CFG_DATA,
    output logic             CFG_ACK,
    input  logic             PLL_LOCK,
    output logic             SDIN,
    output logic             SCLK,
    output logic             SSHIFT,
    output logic             SUPDATE,
    output logic             FAB_RST,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic             LOL
);

    localparam int PH_W  = $clog2(SCLK_DIV + 1);
    localparam int BIT_W = $clog2(CFG_W + 1);
    localparam int ST_W  = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CFG_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [ST_W-1:0]  ST_LIMIT  = ST_W'(LOCK_STABLE);
    localparam logic [ST_W-1:0]  ST_ONE    = ST_W'(1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(LOCK_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

    logic lock_s;

    state_t             state_q, state_d;
    logic [CFG_W-1:0]   shreg_q, shreg_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [ST_W-1:0]    stable_q, stable_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               sclk_q, sclk_d;
    logic               sdin_q, sdin_d;
    logic               sshift_q, sshift_d;
    logic               supdate_q, supdate_d;
    logic               ack_q, ack_d;
    logic               done_q, done_d;
    logic               fab_rst_q, fab_rst_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               lol_q, lol_d;
    logic               accept;

    mss_ccc_lock_sync u_lock_sync (
        .clk      (FAB_CLK),
        .rst      (RESET),
        .async_in (PLL_LOCK),
        .sync_out (lock_s)
    );

    // State, datapath and output registers; reset lands in the power-up lock wait
    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_WAIT_LOCK;
            shreg_q   <= '0;
            phase_q   <= '0;
            bit_q     <= '0;
            stable_q  <= '0;
            tmo_q     <= '0;
            sclk_q    <= 1'b0;
            sdin_q    <= 1'b0;
            sshift_q  <= 1'b0;
            supdate_q <= 1'b0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            fab_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            lol_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            stable_q  <= stable_d;
            tmo_q     <= tmo_d;
            sclk_q    <= sclk_d;
            sdin_q    <= sdin_d;
            sshift_q  <= sshift_d;
            supdate_q <= supdate_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            fab_rst_q <= fab_rst_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            lol_q     <= lol_d;
        end
    end

    // Next-state and next-output logic; every output is registered one level down
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        stable_d  = stable_q;
        tmo_d     = tmo_q;
        sclk_d    = 1'b0;
        sshift_d  = 1'b0;
        supdate_d = 1'b0;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        fab_rst_d = fab_rst_q;
        err_d     = err_q;
        lol_d     = lol_q;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                // A request takes priority over a simultaneous lock drop
                if (CFG_REQ) begin
                    accept = 1'b1;
                end else if ((state_q == ST_IDLE) && !lock_s) begin
                    fab_rst_d = 1'b1;
                    lol_d     = 1'b1;
                    stable_d  = '0;
                    tmo_d     = '0;
                    state_d   = ST_WAIT_LOCK;
                end
            end

            ST_SHIFT: begin
                sshift_d = 1'b1;
                sclk_d   = sclk_q;
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        sclk_d    = 1'b0;
                        sshift_d  = 1'b0;
                        supdate_d = 1'b1;
                        state_d   = ST_UPDATE;
                    end else begin
                        // End of a high phase: start next bit's low phase
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + BIT_ONE;
                        shreg_d = {shreg_q[CFG_W-2:0], 1'b0};
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end

            ST_UPDATE: begin
                supdate_d = 1'b1;
                if (phase_q == PH_LAST) begin
                    supdate_d = 1'b0;
                    phase_d   = '0;
                    stable_d  = '0;
                    tmo_d     = '0;
                    state_d   = ST_WAIT_LOCK;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end

            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    stable_d = (stable_q == ST_LIMIT) ? stable_q : stable_q + ST_ONE;
                end else begin
                    stable_d = '0;
                end
                tmo_d = (tmo_q == TMO_LIMIT) ? tmo_q : tmo_q + TMO_ONE;
                // Success is checked first so it wins a same-cycle tie
                if (stable_d == ST_LIMIT) begin
                    fab_rst_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tmo_d == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end
            end

            default: begin
                fab_rst_d = 1'b1;
                state_d   = ST_WAIT_LOCK;
            end
        endcase

        if (accept) begin
            shreg_d   = CFG_DATA;
            ack_d     = 1'b1;
            fab_rst_d = 1'b1;
            err_d     = 1'b0;
            lol_d     = 1'b0;
            sshift_d  = 1'b1;
            phase_d   = '0;
            bit_d     = '0;
            state_d   = ST_SHIFT;
        end

        // SDIN follows the shift register MSB, which only moves at a low-phase start
        sdin_d = (state_d == ST_SHIFT) ? shreg_d[CFG_W-1] : 1'b0;
        busy_d = (state_d != ST_IDLE) && (state_d != ST_ERROR);
    end

    assign CFG_ACK = ack_q;
    assign SDIN    = sdin_q;
    assign SCLK    = sclk_q;
    assign SSHIFT  = sshift_q;
    assign SUPDATE = supdate_q;
    assign FAB_RST = fab_rst_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign LOL     = lol_q;

endmodule : mss_ccc_reconfig_ctrl
`default_nettype wire

// File: tb/tb_mss_ccc_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mss_ccc_reconfig_ctrl
//  Description : Self-checking bench for mss_ccc_reconfig_ctrl: cycle table for
//                power-up, run-time loss of lock and lock glitch, plus
//                hand-written reconfig, timeout and busy/reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mss_ccc_reconfig_ctrl;

    localparam int CFG_W        = 8;
    localparam int SCLK_DIV     = 2;
    localparam int LOCK_STABLE  = 4;
    localparam int LOCK_TIMEOUT = 50;

    logic             FAB_CLK = 1'b0;
    logic             RESET;
    logic             CFG_REQ;
    logic [CFG_W-1:0] CFG_DATA;
    logic             PLL_LOCK;
    logic             CFG_ACK, SDIN, SCLK, SSHIFT, SUPDATE;
    logic             FAB_RST, BUSY, DONE, ERR, LOL;

    int checks = 0;
    int errors = 0;

    always #5 FAB_CLK = ~FAB_CLK;

    mss_ccc_reconfig_ctrl #(
        .CFG_W        (CFG_W),
        .SCLK_DIV     (SCLK_DIV),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .FAB_CLK  (FAB_CLK),
        .RESET    (RESET),
        .CFG_REQ  (CFG_REQ),
        .CFG_DATA (CFG_DATA),
        .CFG_ACK  (CFG_ACK),
        .PLL_LOCK (PLL_LOCK),
        .SDIN     (SDIN),
        .SCLK     (SCLK),
        .SSHIFT   (SSHIFT),
        .SUPDATE  (SUPDATE),
        .FAB_RST  (FAB_RST),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .LOL      (LOL)
    );

    // exp = {FAB_RST, BUSY, DONE, LOL, ERR, SSHIFT, CFG_ACK, SCLK, SDIN, SUPDATE}
    typedef struct {
        logic       rst;
        logic       lock;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [22];

    function automatic logic [9:0] outs();
        return {FAB_RST, BUSY, DONE, LOL, ERR, SSHIFT, CFG_ACK, SCLK, SDIN, SUPDATE};
    endfunction

    task automatic tick();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] bits;
        int rises, first_rise, sup_cnt, ss_cnt, done_c, err_c, bad, extra_ack;
        logic prev_sclk, prev_sdin;

        RESET    = 1'b1;
        CFG_REQ  = 1'b0;
        CFG_DATA = '0;
        PLL_LOCK = 1'b1;

        // Power-up (rows 0-7), run-time loss (8-10), glitch then relock (11-21)
        tbl[0]  = '{1'b1, 1'b1, 10'b1100000000};
        tbl[1]  = '{1'b0, 1'b1, 10'b1100000000};
        tbl[2]  = '{1'b0, 1'b1, 10'b1100000000};
        tbl[3]  = '{1'b0, 1'b1, 10'b1100000000};
        tbl[4]  = '{1'b0, 1'b1, 10'b1100000000};
        tbl[5]  = '{1'b0, 1'b1, 10'b1100000000};
        tbl[6]  = '{1'b0, 1'b1, 10'b0010000000};
        tbl[7]  = '{1'b0, 1'b1, 10'b0000000000};
        tbl[8]  = '{1'b0, 1'b0, 10'b0000000000};
        tbl[9]  = '{1'b0, 1'b0, 10'b0000000000};
        tbl[10] = '{1'b0, 1'b0, 10'b1101000000};
        tbl[11] = '{1'b0, 1'b1, 10'b1101000000};
        tbl[12] = '{1'b0, 1'b1, 10'b1101000000};
        tbl[13] = '{1'b0, 1'b1, 10'b1101000000};
        tbl[14] = '{1'b0, 1'b0, 10'b1101000000};
        tbl[15] = '{1'b0, 1'b1, 10'b1101000000};
        tbl[16] = '{1'b0, 1'b1, 10'b1101000000};
        tbl[17] = '{1'b0, 1'b1, 10'b1101000000};
        tbl[18] = '{1'b0, 1'b1, 10'b1101000000};
        tbl[19] = '{1'b0, 1'b1, 10'b1101000000};
        tbl[20] = '{1'b0, 1'b1, 10'b0011000000};
        tbl[21] = '{1'b0, 1'b1, 10'b0001000000};

        for (int i = 0; i < 22; i++) begin
            RESET    = tbl[i].rst;
            PLL_LOCK = tbl[i].lock;
            tick();
            check($sformatf("vec%0d", i), {22'd0, outs()}, {22'd0, tbl[i].exp});
        end

        // ---------------- Reconfiguration with 8'hA5 ----------------
        CFG_DATA = 8'hA5;
        CFG_REQ  = 1'b1;
        tick();
        CFG_REQ  = 1'b0;
        check("accept_A5", {26'd0, CFG_ACK, SSHIFT, BUSY, FAB_RST, SDIN, LOL}, 32'b111110);
        bits = '0; rises = 0; first_rise = -1; sup_cnt = 0; ss_cnt = 1;
        done_c = -1; bad = 0; extra_ack = 0;
        prev_sclk = SCLK; prev_sdin = SDIN;
        for (int c = 1; c <= 60 && done_c < 0; c++) begin
            tick();
            if (SCLK && !prev_sclk) begin
                rises++;
                bits = {bits[6:0], SDIN};
                if (first_rise < 0) first_rise = c;
            end
            if ((SDIN !== prev_sdin) && SCLK) bad++;
            if (SUPDATE) begin
                sup_cnt++;
                if (SCLK || SSHIFT) bad++;
            end
            if (SSHIFT) ss_cnt++;
            if (CFG_ACK) extra_ack++;
            if (!DONE && !FAB_RST) bad++;
            if (DONE) done_c = c;
            prev_sclk = SCLK;
            prev_sdin = SDIN;
        end
        check("serial_bits", {24'd0, bits}, 32'hA5);
        check("sclk_rises", rises, 8);
        check("first_rise", first_rise, SCLK_DIV);
        check("supdate_len", sup_cnt, SCLK_DIV);
        check("sshift_len", ss_cnt, 2 * SCLK_DIV * CFG_W);
        check("single_ack", extra_ack, 0);
        check("shift_rules", bad, 0);
        check("done_A5_seen", {31'd0, done_c > 0}, 1);
        check("post_done", {29'd0, FAB_RST, BUSY, LOL}, 0);

        // ---------------- Lock timeout ----------------
        CFG_DATA = 8'h3C;
        PLL_LOCK = 1'b0;
        CFG_REQ  = 1'b1;
        tick();
        CFG_REQ  = 1'b0;
        check("accept_3C", {30'd0, CFG_ACK, SDIN}, 32'b10);
        err_c = -1; bad = 0;
        for (int c = 1; c <= 120 && err_c < 0; c++) begin
            tick();
            if (DONE) bad++;
            if (ERR) err_c = c;
        end
        // 32 shift + 2 update cycles, then 50 cycles in WAIT_LOCK
        check("timeout_cycle", err_c, 2 * SCLK_DIV * CFG_W + SCLK_DIV + LOCK_TIMEOUT);
        check("no_done_timeout", bad, 0);
        check("error_outputs", {27'd0, ERR, FAB_RST, BUSY, LOL, DONE}, 32'b11000);
        for (int c = 0; c < 5; c++) tick();
        check("error_sticky", {27'd0, ERR, FAB_RST, BUSY, SSHIFT, LOL}, 32'b11000);

        // ---------------- Request from ERROR, busy request, reset mid-shift ----------------
        PLL_LOCK = 1'b1;
        CFG_DATA = 8'hC3;
        CFG_REQ  = 1'b1;
        tick();
        check("accept_from_err", {29'd0, CFG_ACK, ERR, SSHIFT}, 32'b101);
        extra_ack = 0; sup_cnt = 0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (CFG_ACK) extra_ack++;
            if (SUPDATE) sup_cnt++;
        end
        check("busy_req_ignored", extra_ack, 0);
        check("shift_in_progress", {31'd0, SSHIFT}, 1);
        RESET   = 1'b1;
        CFG_REQ = 1'b0;
        #1;
        check("async_reset", {22'd0, outs()}, 32'b1100000000);
        tick();
        tick();
        RESET = 1'b0;
        done_c = -1; ss_cnt = 0;
        for (int c = 1; c <= 20 && done_c < 0; c++) begin
            tick();
            if (SUPDATE) sup_cnt++;
            if (SSHIFT) ss_cnt++;
            if (DONE) done_c = c;
        end
        check("no_supdate_after_abort", sup_cnt, 0);
        check("no_reshift_after_reset", ss_cnt, 0);
        check("powerup_done_cycle", done_c, 2 + LOCK_STABLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mss_ccc_reconfig_ctrl
`default_nettype wire
